uart_frame_controller: RTL

Sequences the byte stream from the UART receiver into checksummed command frames for the miner core, such as new work or configuration writes. It tracks frame position, validates length and checksum, and enforces an inter-byte timeout. It resynchronises after errors and requests an ACK/NAK byte from the UART transmitter through a valid/ready handshake. It sits between the receiver's byte-strobe output and the work/config registers of the hashing core.

---
 rtl/uart_frame_pkg.sv | 25 ++
 rtl/uart_gap_timer.sv | 29 ++
 rtl/uart_frame_controller.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame controller.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CHK,
    ACK,
    DISCARD
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_CHECKSUM = 2'd1;
  localparam logic [1:0] ERR_LENGTH   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte silence timer: down-counter reloaded on clear, expire at terminal count.
module uart_gap_timer #(
  parameter int timeout_cycles = 10000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic expire
);

  localparam int W = $clog2(timeout_cycles);
  localparam logic [W-1:0] LOAD = W'(timeout_cycles - 1);

  logic [W-1:0] count;

  // Reaching zero is equivalent to an up-count reaching timeout_cycles-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= LOAD;
    end else if (clear) begin
      count <= LOAD;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/uart_frame_controller.sv
// Assembles CMD/LEN/payload/CHK frames from the UART byte strobe and queues ACK/NAK replies.
//   state   | meaning
//   IDLE    | waiting for a command byte
//   LEN     | waiting for the payload length
//   PAYLOAD | collecting payload bytes into the assembly buffer
//   CHK     | waiting for the checksum byte
//   ACK     | ack/nak byte offered to the transmitter
//   DISCARD | swallowing the rest of a bad frame until the line goes quiet
module uart_frame_controller
  import uart_frame_pkg::*;
#(
  parameter int comm_clk_frequency = 100000000,
  parameter int timeout_cycles     = 10000000,
  parameter int max_payload        = 48
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rx_new_byte,
  input  logic [7:0]               rx_byte,
  output logic                     frame_valid,
  output logic [7:0]               frame_cmd,
  output logic [7:0]               frame_len,
  output logic [8*max_payload-1:0] frame_payload,
  output logic                     err_pulse,
  output logic [1:0]               err_code,
  output logic [15:0]              err_count,
  output logic                     ack_valid,
  output logic [7:0]               ack_byte,
  input  logic                     ack_ready
);

  if (comm_clk_frequency <= 0) begin : g_bad_clk
    $error("comm_clk_frequency must be positive");
  end
  if (timeout_cycles < 2) begin : g_bad_timeout
    $error("timeout_cycles must be at least 2");
  end
  if (max_payload < 1 || max_payload > 255) begin : g_bad_payload
    $error("max_payload must be in 1..255");
  end

  localparam logic [7:0] MAX_LEN = 8'(max_payload);

  state_t                   state;
  logic [7:0]               cmd_q;
  logic [7:0]               len_q;
  logic [7:0]               idx;
  logic [7:0]               sum;
  logic [7:0]               sum_next;
  logic [8*max_payload-1:0] asm_buf;
  logic                     discard_after;
  logic                     gap_clear;
  logic                     gap_expire;
  logic                     timed_state;
  logic                     frame_timeout;
  logic                     ack_done;

  assign sum_next      = sum + rx_byte;
  assign ack_done      = ack_valid & ack_ready;
  assign timed_state   = (state == LEN) || (state == PAYLOAD) || (state == CHK) || (state == DISCARD);
  assign frame_timeout = gap_expire && !rx_new_byte &&
                         ((state == LEN) || (state == PAYLOAD) || (state == CHK));
  // Every state entry is caused by a byte, an expiry or an ack handshake, so these cover all restarts.
  assign gap_clear     = rx_new_byte | (gap_expire & timed_state) | ack_done;

  uart_gap_timer #(
    .timeout_cycles(timeout_cycles)
  ) u_gap_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (gap_clear),
    .expire (gap_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cmd_q         <= '0;
      len_q         <= '0;
      idx           <= '0;
      sum           <= '0;
      asm_buf       <= '0;
      discard_after <= 1'b0;
      frame_valid   <= 1'b0;
      frame_cmd     <= '0;
      frame_len     <= '0;
      frame_payload <= '0;
      err_pulse     <= 1'b0;
      err_code      <= ERR_NONE;
      err_count     <= '0;
      ack_valid     <= 1'b0;
      ack_byte      <= ACK_BYTE;
    end else begin
      frame_valid <= 1'b0;
      err_pulse   <= 1'b0;
      if (frame_timeout) begin
        err_pulse     <= 1'b1;
        err_code      <= ERR_TIMEOUT;
        err_count     <= sat_inc(err_count);
        ack_byte      <= NAK_BYTE;
        ack_valid     <= 1'b1;
        discard_after <= 1'b0;
        state         <= ACK;
      end else begin
        case (state)
          IDLE: begin
            if (rx_new_byte) begin
              cmd_q   <= rx_byte;
              sum     <= rx_byte;
              asm_buf <= '0;
              state   <= LEN;
            end
          end
          LEN: begin
            if (rx_new_byte) begin
              sum <= sum_next;
              if (rx_byte == 8'd0 || rx_byte > MAX_LEN) begin
                err_pulse     <= 1'b1;
                err_code      <= ERR_LENGTH;
                err_count     <= sat_inc(err_count);
                ack_byte      <= NAK_BYTE;
                ack_valid     <= 1'b1;
                discard_after <= 1'b1;
                state         <= ACK;
              end else begin
                len_q <= rx_byte;
                idx   <= '0;
                state <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            if (rx_new_byte) begin
              for (int i = 0; i < max_payload; i++) begin
                if (idx == 8'(i)) asm_buf[8*i +: 8] <= rx_byte;
              end
              sum <= sum_next;
              idx <= idx + 8'd1;
              if (idx + 8'd1 == len_q) state <= CHK;
            end
          end
          CHK: begin
            if (rx_new_byte) begin
              discard_after <= 1'b0;
              ack_valid     <= 1'b1;
              state         <= ACK;
              if (sum_next == 8'h00) begin
                frame_cmd     <= cmd_q;
                frame_len     <= len_q;
                frame_payload <= asm_buf;
                frame_valid   <= 1'b1;
                ack_byte      <= ACK_BYTE;
              end else begin
                err_pulse <= 1'b1;
                err_code  <= ERR_CHECKSUM;
                err_count <= sat_inc(err_count);
                ack_byte  <= NAK_BYTE;
              end
            end
          end
          ACK: begin
            // A byte landing here has nowhere to go; it is only counted.
            if (rx_new_byte) err_count <= sat_inc(err_count);
            if (ack_done) begin
              ack_valid <= 1'b0;
              state     <= discard_after ? DISCARD : IDLE;
            end
          end
          DISCARD: begin
            if (gap_expire && !rx_new_byte) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
